// File: rtl/gcn_argmax_scanner_if.sv
// Bus between the argmax scanner and its surroundings: scan control, the
// row-addressed matrix memory port and the per-row argmax results.
interface gcn_argmax_scanner_if #(
   parameter int FEATURE_ROWS   = 6,
   parameter int WEIGHT_COLS    = 3,
   parameter int DOT_PROD_WIDTH = 16,
   parameter int FEATURE_WIDTH  = $clog2(FEATURE_ROWS),
   parameter int WEIGHT_WIDTH   = $clog2(WEIGHT_COLS)
);
   logic                      start;
   logic [FEATURE_WIDTH-1:0]  read_row;
   logic [DOT_PROD_WIDTH-1:0] fm_wm_adj_out   [0:WEIGHT_COLS-1];
   logic [WEIGHT_WIDTH-1:0]   max_addi_answer [0:FEATURE_ROWS-1];
   logic                      busy;
   logic                      done;

   modport slave (
      input  start, fm_wm_adj_out,
      output read_row, max_addi_answer, busy, done
   );

   modport master (
      output start, fm_wm_adj_out,
      input  read_row, max_addi_answer, busy, done
   );
endinterface

// File: rtl/gcn_argmax_scanner.sv
// Scans every row of the GCN result memory once per start request and stores
// the index of the largest (unsigned, lowest index on ties) column per row.
module gcn_argmax_scanner #(
   parameter int FEATURE_ROWS   = 6,
   parameter int WEIGHT_COLS    = 3,
   parameter int DOT_PROD_WIDTH = 16,
   parameter int FEATURE_WIDTH  = $clog2(FEATURE_ROWS),
   parameter int WEIGHT_WIDTH   = $clog2(WEIGHT_COLS)
) (
   input logic                 clk,
   input logic                 rst,
   gcn_argmax_scanner_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

   localparam logic [FEATURE_WIDTH-1:0] LAST_ROW = FEATURE_WIDTH'(FEATURE_ROWS - 1);

   state_t                    state_q, state_d;
   logic [FEATURE_WIDTH-1:0]  row_cnt_q, row_cnt_d;
   logic [FEATURE_WIDTH-1:0]  row_idx_q, row_idx_d;
   logic                      stage_valid_q, stage_valid_d;
   logic [DOT_PROD_WIDTH-1:0] row_data_q [0:WEIGHT_COLS-1];
   logic [DOT_PROD_WIDTH-1:0] row_data_d [0:WEIGHT_COLS-1];
   logic [WEIGHT_WIDTH-1:0]   answer_q   [0:FEATURE_ROWS-1];
   logic [WEIGHT_WIDTH-1:0]   answer_d   [0:FEATURE_ROWS-1];
   logic [WEIGHT_WIDTH-1:0]   argmax_idx;
   logic [DOT_PROD_WIDTH-1:0] argmax_val;

   // Strict greater-than keeps the earliest column when values tie.
   always_comb begin
      argmax_idx = '0;
      argmax_val = row_data_q[0];
      for (int c = 1; c < WEIGHT_COLS; c++) begin
         if (row_data_q[c] > argmax_val) begin
            argmax_val = row_data_q[c];
            argmax_idx = WEIGHT_WIDTH'(c);
         end
      end
   end

   always_comb begin
      state_d       = state_q;
      row_cnt_d     = row_cnt_q;
      row_idx_d     = row_idx_q;
      stage_valid_d = stage_valid_q;
      for (int c = 0; c < WEIGHT_COLS; c++) begin
         row_data_d[c] = row_data_q[c];
      end
      case (state_q)
         IDLE: begin
            stage_valid_d = 1'b0;
            if (bus.start) begin
               state_d   = SCAN;
               row_cnt_d = '0;
            end
         end
         SCAN: begin
            for (int c = 0; c < WEIGHT_COLS; c++) begin
               row_data_d[c] = bus.fm_wm_adj_out[c];
            end
            row_idx_d     = row_cnt_q;
            stage_valid_d = 1'b1;
            // The counter parks on the last row instead of wrapping.
            if (row_cnt_q == LAST_ROW) begin
               state_d = DRAIN;
            end else begin
               row_cnt_d = row_cnt_q + FEATURE_WIDTH'(1);
            end
         end
         DRAIN: begin
            stage_valid_d = 1'b0;
            state_d       = DONE;
         end
         DONE: begin
            stage_valid_d = 1'b0;
            state_d       = IDLE;
         end
         default: begin
            stage_valid_d = 1'b0;
            state_d       = IDLE;
         end
      endcase
   end

   always_comb begin
      for (int r = 0; r < FEATURE_ROWS; r++) begin
         answer_d[r] = answer_q[r];
         if (stage_valid_q && (row_idx_q == FEATURE_WIDTH'(r))) begin
            answer_d[r] = argmax_idx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= IDLE;
         row_cnt_q     <= '0;
         row_idx_q     <= '0;
         stage_valid_q <= 1'b0;
         for (int c = 0; c < WEIGHT_COLS; c++) begin
            row_data_q[c] <= '0;
         end
         for (int r = 0; r < FEATURE_ROWS; r++) begin
            answer_q[r] <= '0;
         end
      end else begin
         state_q       <= state_d;
         row_cnt_q     <= row_cnt_d;
         row_idx_q     <= row_idx_d;
         stage_valid_q <= stage_valid_d;
         for (int c = 0; c < WEIGHT_COLS; c++) begin
            row_data_q[c] <= row_data_d[c];
         end
         for (int r = 0; r < FEATURE_ROWS; r++) begin
            answer_q[r] <= answer_d[r];
         end
      end
   end

   always_comb begin
      for (int r = 0; r < FEATURE_ROWS; r++) begin
         bus.max_addi_answer[r] = answer_q[r];
      end
   end

   assign bus.read_row = (state_q == SCAN) ? row_cnt_q : '0;
   assign bus.busy     = (state_q != IDLE);
   assign bus.done     = (state_q == DONE);
endmodule

// File: tb/tb_gcn_argmax_scanner.sv
// Bench for gcn_argmax_scanner: table of memory images with hand-derived
// argmax results, plus hold-start, mid-scan reset and stale-memory sequences.
module tb_gcn_argmax_scanner;
   typedef logic [5:0][1:0] ans_t;

   typedef struct packed {
      logic [5:0][2:0][15:0] rows;
      ans_t                  exp;
   } vec_t;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   vec_t                  vecs [0:2];
   logic [5:0][2:0][15:0] mem_rows;
   ans_t                  sbq [$];

   gcn_argmax_scanner_if bus ();

   gcn_argmax_scanner dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational matrix memory answering whatever row the scanner addresses.
   always_comb begin
      for (int c = 0; c < 3; c++) begin
         bus.fm_wm_adj_out[c] = (bus.read_row < 3'd6) ? mem_rows[bus.read_row][c] : 16'h0;
      end
   end

   task automatic check_output(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
      end
   endtask

   task automatic set_row(input int v, input int r, input logic [15:0] a,
                          input logic [15:0] b, input logic [15:0] c, input logic [1:0] e);
      vecs[v].rows[r][0] = a;
      vecs[v].rows[r][1] = b;
      vecs[v].rows[r][2] = c;
      vecs[v].exp[r]     = e;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic compare_answers();
      ans_t e;
      if (sbq.size() == 0) begin
         check_output("queue_depth_at_done", sbq.size(), 1);
      end else begin
         e = sbq.pop_front();
         for (int r = 0; r < 6; r++) begin
            check_output($sformatf("answer[%0d]", r), int'(bus.max_addi_answer[r]), int'(e[r]));
         end
      end
   endtask

   // One full scan of table entry v, sampled once per cycle after each edge.
   task automatic apply_stimulus(input int v);
      mem_rows = vecs[v].rows;
      sbq.push_back(vecs[v].exp);
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      for (int k = 0; k < 10; k++) begin
         check_output($sformatf("read_row k=%0d", k), int'(bus.read_row), (k <= 5) ? k : 0);
         check_output($sformatf("busy k=%0d", k), int'(bus.busy), (k <= 7) ? 1 : 0);
         check_output($sformatf("done k=%0d", k), int'(bus.done), (k == 7) ? 1 : 0);
         if (bus.done) compare_answers();
         step();
      end
      check_output("pending_results", sbq.size(), 0);
      sbq.delete();
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      rst       = 1'b0;
      bus.start = 1'b0;
      mem_rows  = '0;

      set_row(0, 0, 16'd1,    16'd5,    16'd2, 2'd1);
      set_row(0, 1, 16'd9,    16'd0,    16'd0, 2'd0);
      set_row(0, 2, 16'd0,    16'd0,    16'd7, 2'd2);
      set_row(0, 3, 16'd3,    16'd3,    16'd3, 2'd0);
      set_row(0, 4, 16'd0,    16'd8,    16'd8, 2'd1);
      set_row(0, 5, 16'hFFFF, 16'hFFFE, 16'd0, 2'd0);

      set_row(1, 0, 16'd0,    16'd0,    16'd0, 2'd0);
      set_row(1, 1, 16'd7,    16'd7,    16'd9, 2'd2);
      set_row(1, 2, 16'd10,   16'd20,   16'd20, 2'd1);
      set_row(1, 3, 16'h8000, 16'h7FFF, 16'd0, 2'd0);
      set_row(1, 4, 16'd1,    16'd2,    16'd3, 2'd2);
      set_row(1, 5, 16'd5,    16'd4,    16'd5, 2'd0);

      set_row(2, 0, 16'hFFFF, 16'hFFFF, 16'hFFFF, 2'd0);
      set_row(2, 1, 16'd0,    16'd1,    16'd0, 2'd1);
      set_row(2, 2, 16'd0,    16'd0,    16'd1, 2'd2);
      set_row(2, 3, 16'hFFFE, 16'hFFFF, 16'hFFFF, 2'd1);
      set_row(2, 4, 16'd2,    16'd1,    16'd0, 2'd0);
      set_row(2, 5, 16'd0,    16'd0,    16'd0, 2'd0);

      #1;
      check_output("reset busy", int'(bus.busy), 0);
      check_output("reset done", int'(bus.done), 0);
      check_output("reset read_row", int'(bus.read_row), 0);
      for (int r = 0; r < 6; r++) begin
         check_output($sformatf("reset answer[%0d]", r), int'(bus.max_addi_answer[r]), 0);
      end
      step();
      rst = 1'b1;
      step();

      for (int v = 0; v < 3; v++) begin
         $display("[TB] table scan %0d", v);
         apply_stimulus(v);
      end

      $display("[TB] results hold while memory changes");
      apply_stimulus(0);
      mem_rows = vecs[1].rows;
      repeat (10) step();
      for (int r = 0; r < 6; r++) begin
         check_output($sformatf("held answer[%0d]", r), int'(bus.max_addi_answer[r]), int'(vecs[0].exp[r]));
      end
      apply_stimulus(1);

      $display("[TB] start held high across three scans");
      mem_rows  = vecs[2].rows;
      bus.start = 1'b1;
      step();
      for (int k = 0; k < 27; k++) begin
         if (k % 9 == 0) sbq.push_back(vecs[2].exp);
         check_output($sformatf("hold read_row k=%0d", k), int'(bus.read_row), (k % 9 <= 5) ? k % 9 : 0);
         check_output($sformatf("hold busy k=%0d", k), int'(bus.busy), (k % 9 != 8) ? 1 : 0);
         check_output($sformatf("hold done k=%0d", k), int'(bus.done), (k % 9 == 7) ? 1 : 0);
         if (bus.done) compare_answers();
         if (k == 25) bus.start = 1'b0;
         step();
      end
      check_output("hold pending_results", sbq.size(), 0);
      sbq.delete();

      $display("[TB] reset during scan cycle 3");
      mem_rows  = vecs[0].rows;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      repeat (3) step();
      check_output("pre-reset read_row", int'(bus.read_row), 3);
      rst = 1'b0;
      #1;
      check_output("abort busy", int'(bus.busy), 0);
      check_output("abort done", int'(bus.done), 0);
      check_output("abort read_row", int'(bus.read_row), 0);
      for (int r = 0; r < 6; r++) begin
         check_output($sformatf("abort answer[%0d]", r), int'(bus.max_addi_answer[r]), 0);
      end
      step();
      rst = 1'b1;
      step();
      check_output("post-release busy", int'(bus.busy), 0);
      apply_stimulus(0);

      $display("[TB] CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end
endmodule

// File: doc/gcn_argmax_scanner.md
GCN_ARGMAX_SCANNER -- requirements
Module: gcn_argmax_scanner

Interface
REQ-001 The block SHALL have parameter FEATURE_ROWS, default 6, number of node rows in the result memory.
REQ-002 The block SHALL have parameter WEIGHT_COLS, default 3, number of class columns per row.
REQ-003 The block SHALL have parameter DOT_PROD_WIDTH, default 16, width of each stored value.
REQ-004 The block SHALL have parameter FEATURE_WIDTH, default $clog2(FEATURE_ROWS), row address width.
REQ-005 The block SHALL have parameter WEIGHT_WIDTH, default $clog2(WEIGHT_COLS), class index width.
REQ-006 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port rst, input, 1, reset; asynchronous and active-low (asserted when 0).
REQ-008 The block SHALL have port start, input, 1, request to scan the whole memory.
REQ-009 The block SHALL have port read_row, output, FEATURE_WIDTH, row address driven to the upstream matrix memory.
REQ-010 The block SHALL have port fm_wm_adj_out, input, DOT_PROD_WIDTH x [0:WEIGHT_COLS-1], combinational row data returned for read_row.
REQ-011 The block SHALL have port max_addi_answer, output, WEIGHT_WIDTH x [0:FEATURE_ROWS-1], per-row argmax class index.
REQ-012 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-013 The block SHALL have port done, output, 1, one-cycle pulse when all results are written.

Function
REQ-014 FSM states SHALL be IDLE, SCAN, DRAIN and DONE.
REQ-015 IDLE: start=1 at a rising edge -> SCAN with row_cnt=0; start=0 -> stay IDLE.
REQ-016 start SHALL be ignored in SCAN, DRAIN and DONE; no restart or queuing.
REQ-017 SCAN: read_row SHALL equal row_cnt; read_row SHALL be 0 in all other states.
REQ-018 SCAN edge: capture fm_wm_adj_out into a row register, capture row_cnt into a row-index register, set stage_valid=1, increment row_cnt.
REQ-019 SCAN SHALL last exactly FEATURE_ROWS cycles; the edge capturing row FEATURE_ROWS-1 moves the state to DRAIN.
REQ-020 On every edge with stage_valid=1, max_addi_answer[row-index register] SHALL be loaded with the argmax of the row register.
REQ-021 stage_valid SHALL clear on the edge leaving DRAIN; it SHALL be 0 in IDLE and DONE.
REQ-022 DRAIN SHALL last one cycle, then go to DONE; DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-023 Latency: with start sampled at edge E0, done SHALL be high in the cycle after edge E(FEATURE_ROWS+1); this is 8 cycles at defaults.
REQ-024 Argmax compare SHALL be unsigned over full DOT_PROD_WIDTH; the largest value wins.
REQ-025 On ties, the lowest column index SHALL win (all-equal row -> 0).
REQ-026 Argmax SHALL be combinational from the row register; no extra pipeline stage.
REQ-027 max_addi_answer SHALL hold its values between scans; each new scan overwrites every entry.
REQ-028 row_cnt SHALL not wrap during a scan; it SHALL be reset to 0 on entry to SCAN.

Reset
REQ-029 rst=0 SHALL immediately force: state IDLE, row_cnt=0, stage_valid=0, all max_addi_answer entries=0, busy=0, done=0, read_row=0.
REQ-030 Reset mid-scan SHALL abort the scan with no partial results kept; the next start after release performs a full scan.

Verification
REQ-031 Rows = {[1,5,2],[9,0,0],[0,0,7],[3,3,3],[0,8,8],[FFFF,FFFE,0]}, pulse start -> done at start+8 cycles; max_addi_answer = {1,0,2,0,1,0}; busy high 8 cycles.
REQ-032 Observe read_row during a scan -> 0,1,2,3,4,5 on consecutive cycles, then 0; exactly one done pulse.
REQ-033 Hold start=1 continuously -> each scan completes in full, done every 9 cycles, no mid-scan restart.
REQ-034 Assert rst=0 at scan cycle 3 -> all outputs 0 immediately; after release a new start yields correct full results.
REQ-035 Scan once, change memory contents, leave start=0 -> max_addi_answer unchanged; a second start -> updated results.
